csr_trap_unit_irq: RTL and testbench

Parametrised machine-mode CSR and trap unit, successor to the single-cycle CSR/exception handler in the multicycle rv32ima core.
- Adds registered interrupt arbitration across MSI/MTI/MEI plus NUM_LOCAL_IRQ platform lines (mip/mie bits 16+).
- Adds WFI sleep state, vectored-mode interrupt dispatch, WARL mtvec and configurable counter width.
- Sits beside the control FSM: the FSM reports instruction boundaries; the unit returns trap redirects and a stall.

---
 rtl/csr_trap_unit_irq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_csr_trap_unit_irq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_irq.sv
// Machine-mode CSR file and trap unit with registered interrupt arbitration.
// Handles MSI/MTI/MEI plus NUM_LOCAL_IRQ platform lines (mip/mie bits 16+),
// WFI sleep, vectored interrupt dispatch, WARL mtvec and cycle/instret counters.
// Optional feature macro: CSR_MCOUNTINHIBIT_EN (implements mcountinhibit at 0x320).
// csr_op_i encoding: [2] selects uimm as operand, [1:0] = 01 write, 10 set, 11 clear.

`ifndef CSR_OP_WIDTH
`define CSR_OP_WIDTH 3
`endif

module csr_trap_unit_irq #(
    parameter logic [31:0] MTVEC_INIT    = 32'h0000_0000,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [31:0] HARTID        = 32'h0000_0000
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            incr_inst_retired_i,
    input  logic [11:0]                                     csr_addr_i,
    input  logic [`CSR_OP_WIDTH-1:0]                        csr_op_i,
    input  logic                                            csr_we_i,
    input  logic                                            csr_re_i,
    input  logic [31:0]                                     rs1_data_i,
    input  logic [4:0]                                      uimm_i,
    input  logic                                            exception_event_i,
    input  logic [31:0]                                     cause_i,
    input  logic [31:0]                                     pc_i,
    input  logic [31:0]                                     badaddr_i,
    input  logic                                            mret_i,
    input  logic                                            wfi_i,
    input  logic                                            insn_boundary_i,
    input  logic                                            irq_msip_i,
    input  logic                                            irq_mtip_i,
    input  logic                                            irq_meip_i,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_i,
    output logic [31:0]                                     rdata_o,
    output logic                                            trap_valid_o,
    output logic [31:0]                                     trap_pc_o,
    output logic                                            wfi_stall_o,
    output logic [1:0]                                      privilege_mode_o,
    output logic                                            csr_access_fault_o,
    output logic [31:0]                                     mstatus_o,
    output logic [31:0]                                     mie_o,
    output logic [31:0]                                     mip_o
);

    localparam logic [1:0]  PRIV_M     = 2'b11;
    localparam logic [1:0]  PRIV_U     = 2'b00;
    localparam logic [31:0] MISA_VAL   = 32'h4010_1101;
    localparam logic [31:0] MVENDORID  = 32'h6b69_616e;
    localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

    typedef enum logic {ST_RUN, ST_SLEEP} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               priv_q, priv_d;
    logic                     st_mie_q, st_mie_d, st_mpie_q, st_mpie_d, st_mprv_q, st_mprv_d;
    logic [1:0]               st_mpp_q, st_mpp_d;
    logic [31:0]              mie_q, mie_d, mip_q, mip_d, mtvec_q, mtvec_d;
    logic [31:0]              mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0]              mcause_q, mcause_d, mtval_q, mtval_d;
    logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;
    logic                     trap_valid_q, trap_valid_d;
    logic [31:0]              trap_pc_q, trap_pc_d;

    logic [63:0] cycle64, instret64, cnt_tmp;
    logic [31:0] csr_rval, wdata, opnd, pend;
    logic [4:0]  irq_code;
    logic        irq_pend, irq_en, irq_take, exc_take, mret_take, csr_write;
    logic        inh_cy, inh_ir;

    assign cycle64   = 64'(cycle_q);
    assign instret64 = 64'(instret_q);
    assign mstatus_o = {14'd0, st_mprv_q, 4'd0, st_mpp_q, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};
    assign mie_o            = mie_q;
    assign mip_o            = mip_q;
    assign privilege_mode_o = priv_q;
    assign trap_valid_o     = trap_valid_q;
    assign trap_pc_o        = trap_pc_q;

    assign pend      = mip_q & mie_q;
    assign irq_pend  = |pend;
    assign irq_en    = st_mie_q || (priv_q == PRIV_U);
    assign exc_take  = exception_event_i;
    assign irq_take  = irq_en && irq_pend && insn_boundary_i && !exception_event_i;
    assign mret_take = mret_i && !exception_event_i;
    assign csr_write = csr_we_i && !csr_access_fault_o && !exception_event_i && !mret_i && !irq_take;

`ifdef CSR_MCOUNTINHIBIT_EN
    logic inh_cy_q, inh_ir_q;

    // mcountinhibit: CY and IR freeze bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else if (csr_write && csr_addr_i == 12'h320) begin
            inh_cy_q <= wdata[0];
            inh_ir_q <= wdata[2];
        end
    end

    assign inh_cy = inh_cy_q;
    assign inh_ir = inh_ir_q;
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    // Interrupt arbitration: MEI > MSI > MTI > locals, highest local index first
    always_comb begin
        irq_code = 5'd0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            if (pend[16+i]) irq_code = 5'(16 + i);
        end
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;
    end

    // CSR read mux, privilege/read-only checks and read-modify-write data
    always_comb begin
        csr_rval = 32'h0;
        case (csr_addr_i)
            12'h300: csr_rval = mstatus_o;
            12'h301: csr_rval = MISA_VAL;
            12'h304: csr_rval = mie_q;
            12'h305: csr_rval = mtvec_q;
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: csr_rval = {29'd0, inh_ir, 1'b0, inh_cy};
`endif
            12'h340: csr_rval = mscratch_q;
            12'h341: csr_rval = mepc_q;
            12'h342: csr_rval = mcause_q;
            12'h343: csr_rval = mtval_q;
            12'h344: csr_rval = mip_q;
            12'hB00, 12'hC00, 12'hC01: csr_rval = cycle64[31:0];
            12'hB80, 12'hC80, 12'hC81: csr_rval = cycle64[63:32];
            12'hB02, 12'hC02:          csr_rval = instret64[31:0];
            12'hB82, 12'hC82:          csr_rval = instret64[63:32];
            12'hF11: csr_rval = MVENDORID;
            12'hF14: csr_rval = HARTID;
            default: csr_rval = 32'h0;
        endcase
        rdata_o = csr_re_i ? csr_rval : 32'h0;

        csr_access_fault_o = ((csr_re_i || csr_we_i) && (priv_q < csr_addr_i[9:8]))
                           || (csr_we_i && csr_addr_i[11:10] == 2'b11);

        opnd = csr_op_i[2] ? {27'd0, uimm_i} : rs1_data_i;
        case (csr_op_i[1:0])
            2'b10:   wdata = csr_rval | opnd;
            2'b11:   wdata = csr_rval & ~opnd;
            default: wdata = opnd;
        endcase
    end

    // Sleep FSM next state; any pending enabled interrupt wakes regardless of MIE
    always_comb begin
        state_d     = state_q;
        wfi_stall_o = 1'b0;
        case (state_q)
            ST_RUN:   if (wfi_i && !irq_pend) state_d = ST_SLEEP;
            ST_SLEEP: begin
                wfi_stall_o = 1'b1;
                if (irq_pend) state_d = ST_RUN;
            end
            default:  state_d = ST_RUN;
        endcase
    end

    // Architectural next state: CSR writes, trap entry, mret, counters
    always_comb begin
        priv_d       = priv_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        st_mpp_d     = st_mpp_q;
        st_mprv_d    = st_mprv_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        cycle_d      = inh_cy ? cycle_q : cycle_q + COUNTER_WIDTH'(1);
        instret_d    = (incr_inst_retired_i && !inh_ir) ? instret_q + COUNTER_WIDTH'(1) : instret_q;
        trap_valid_d = 1'b0;
        trap_pc_d    = trap_pc_q;
        cnt_tmp      = 64'd0;

        mip_d     = 32'h0;
        mip_d[3]  = irq_msip_i;
        mip_d[7]  = irq_mtip_i;
        mip_d[11] = irq_meip_i;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip_d[16+i] = irq_local_i[i];
        end

        if (csr_write) begin
            case (csr_addr_i)
                12'h300: begin
                    st_mie_d  = wdata[3];
                    st_mpie_d = wdata[7];
                    st_mpp_d  = (wdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                    st_mprv_d = wdata[17];
                end
                12'h304: mie_d      = wdata & MIE_MASK;
                12'h305: mtvec_d    = {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
                12'h340: mscratch_d = wdata;
                12'h341: mepc_d     = wdata;
                12'h342: mcause_d   = wdata;
                12'h343: mtval_d    = wdata;
                12'hB00: begin cnt_tmp = cycle64;   cnt_tmp[31:0]  = wdata; cycle_d   = cnt_tmp[COUNTER_WIDTH-1:0]; end
                12'hB80: begin cnt_tmp = cycle64;   cnt_tmp[63:32] = wdata; cycle_d   = cnt_tmp[COUNTER_WIDTH-1:0]; end
                12'hB02: begin cnt_tmp = instret64; cnt_tmp[31:0]  = wdata; instret_d = cnt_tmp[COUNTER_WIDTH-1:0]; end
                12'hB82: begin cnt_tmp = instret64; cnt_tmp[63:32] = wdata; instret_d = cnt_tmp[COUNTER_WIDTH-1:0]; end
                default: ;
            endcase
        end

        if (exc_take || irq_take) begin
            mepc_d       = pc_i;
            mcause_d     = exc_take ? cause_i : {1'b1, 26'd0, irq_code};
            mtval_d      = !exc_take ? 32'h0 : ((badaddr_i == 32'hFFFF_FFFF) ? pc_i : badaddr_i);
            st_mpie_d    = st_mie_q;
            st_mie_d     = 1'b0;
            st_mpp_d     = priv_q;
            priv_d       = PRIV_M;
            trap_valid_d = 1'b1;
            trap_pc_d    = {mtvec_q[31:2], 2'b00}
                         + ((irq_take && mtvec_q[1:0] == 2'b01) ? {25'd0, irq_code, 2'b00} : 32'h0);
        end else if (mret_take) begin
            st_mie_d     = st_mpie_q;
            st_mpie_d    = 1'b1;
            st_mpp_d     = PRIV_U;
            if (st_mpp_q != PRIV_M) st_mprv_d = 1'b0;
            priv_d       = st_mpp_q;
            trap_valid_d = 1'b1;
            trap_pc_d    = mepc_q;
        end
    end

    // Sleep FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Architectural state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            priv_q       <= PRIV_M;
            st_mie_q     <= 1'b0;
            st_mpie_q    <= 1'b0;
            st_mpp_q     <= PRIV_M;
            st_mprv_q    <= 1'b0;
            mie_q        <= 32'h0;
            mip_q        <= 32'h0;
            mtvec_q      <= MTVEC_INIT;
            mscratch_q   <= 32'h0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            cycle_q      <= '0;
            instret_q    <= '0;
            trap_valid_q <= 1'b0;
            trap_pc_q    <= 32'h0;
        end else begin
            priv_q       <= priv_d;
            st_mie_q     <= st_mie_d;
            st_mpie_q    <= st_mpie_d;
            st_mpp_q     <= st_mpp_d;
            st_mprv_q    <= st_mprv_d;
            mie_q        <= mie_d;
            mip_q        <= mip_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            trap_valid_q <= trap_valid_d;
            trap_pc_q    <= trap_pc_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit_irq.sv
// Bench for csr_trap_unit_irq: architectural model updated every clock and
// compared against the DUT on every falling edge, plus directed literal checks.

`ifndef CSR_OP_WIDTH
`define CSR_OP_WIDTH 3
`endif

module tb_csr_trap_unit_irq;

    localparam int          NL   = 4;
    localparam logic [31:0] MTV0 = 32'h8000_0001;
    localparam logic [2:0]  OP_RW = 3'b001, OP_RS = 3'b010, OP_RC = 3'b011;
    localparam logic [2:0]  OP_RWI = 3'b101, OP_RSI = 3'b110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, incr, csr_we, csr_re, exc, mret, wfi, bnd, msip, mtip, meip;
    logic [11:0] addr;
    logic [2:0]  op;
    logic [31:0] rs1, cause, pc, badaddr;
    logic [4:0]  uimm;
    logic [NL-1:0] loc;
    logic [31:0] rdata, trap_pc, mstatus, mie, mip;
    logic        trap_valid, stall, fault;
    logic [1:0]  priv;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;

    csr_trap_unit_irq #(.MTVEC_INIT(MTV0), .NUM_LOCAL_IRQ(NL), .COUNTER_WIDTH(64), .HARTID(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .incr_inst_retired_i(incr), .csr_addr_i(addr), .csr_op_i(op),
        .csr_we_i(csr_we), .csr_re_i(csr_re), .rs1_data_i(rs1), .uimm_i(uimm),
        .exception_event_i(exc), .cause_i(cause), .pc_i(pc), .badaddr_i(badaddr), .mret_i(mret),
        .wfi_i(wfi), .insn_boundary_i(bnd), .irq_msip_i(msip), .irq_mtip_i(mtip), .irq_meip_i(meip),
        .irq_local_i(loc), .rdata_o(rdata), .trap_valid_o(trap_valid), .trap_pc_o(trap_pc),
        .wfi_stall_o(stall), .privilege_mode_o(priv), .csr_access_fault_o(fault),
        .mstatus_o(mstatus), .mie_o(mie), .mip_o(mip));

    // ---------------- architectural model ----------------
    bit [1:0]        m_priv, m_mpp;
    bit              m_mie_b, m_mpie, m_mprv, m_sleep, m_tv;
    bit [31:0]       m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_tpc;
    bit [2:0]        m_inh;
    longint unsigned m_cyc, m_ret;

    function automatic bit [31:0] m_status();
        return (m_mprv ? 32'h2_0000 : 32'h0) | (32'(m_mpp) << 11)
             | (m_mpie ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
    endfunction

    function automatic bit [31:0] ie_mask();
        bit [31:0] m = 32'h8 | 32'h80 | 32'h800;
        for (int i = 0; i < NL; i++) m = m | (32'h1 << (16 + i));
        return m;
    endfunction

    function automatic int m_code(input bit [31:0] p);
        int order[3+NL];
        order[0] = 11; order[1] = 3; order[2] = 7;
        for (int i = 0; i < NL; i++) order[3+i] = 16 + NL - 1 - i;
        foreach (order[k]) if (p[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300: return m_status();
            12'h301: return 32'h4000_0000 | 32'h1 | 32'h100 | 32'h1000 | 32'h10_0000;
            12'h304: return m_ie;
            12'h305: return m_tvec;
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: return 32'(m_inh) & 32'h5;
`endif
            12'h340: return m_scratch;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h343: return m_tval;
            12'h344: return m_ip;
            12'hB00, 12'hC00, 12'hC01: return m_cyc[31:0];
            12'hB80, 12'hC80, 12'hC81: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ret[31:0];
            12'hB82, 12'hC82: return m_ret[63:32];
            12'hF11: return 32'h6b69_616e;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_fault();
        int need = int'(addr[9:8]);
        return ((csr_re || csr_we) && int'(m_priv) < need) || (csr_we && addr[11:10] == 2'b11);
    endfunction

    task automatic model_step();
        bit [31:0] p, old, w, nv;
        int code;
        bit take_exc, take_irq, do_mret, do_wr, wr_cyc, wr_ret;
        if (rst) begin
            m_priv = 2'd3; m_mpp = 2'd3; m_mie_b = 0; m_mpie = 0; m_mprv = 0;
            m_ie = 0; m_ip = 0; m_tvec = MTV0; m_scratch = 0; m_epc = 0; m_cause = 0; m_tval = 0;
            m_cyc = 0; m_ret = 0; m_sleep = 0; m_tv = 0; m_tpc = 0; m_inh = 0;
            return;
        end
        p        = m_ip & m_ie;
        code     = m_code(p);
        take_exc = exc;
        take_irq = (m_mie_b || m_priv == 2'd0) && p != 0 && bnd && !exc;
        do_mret  = mret && !exc;
        do_wr    = csr_we && !m_fault() && !exc && !mret && !take_irq;
        wr_cyc = 0; wr_ret = 0;
        m_tv = 0;
        if (do_wr) begin
            old = m_read(addr);
            w   = op[2] ? 32'(uimm) : rs1;
            case (op[1:0])
                2'b10:   nv = old | w;
                2'b11:   nv = old & ~w;
                default: nv = w;
            endcase
            case (addr)
                12'h300: begin
                    m_mie_b = nv[3]; m_mpie = nv[7]; m_mprv = nv[17];
                    m_mpp = (nv[12:11] == 2'd3) ? 2'd3 : 2'd0;
                end
                12'h304: m_ie = nv & ie_mask();
                12'h305: m_tvec = nv[1] ? (nv & ~32'h3) : nv;
`ifdef CSR_MCOUNTINHIBIT_EN
                12'h320: m_inh = {nv[2], 1'b0, nv[0]};
`endif
                12'h340: m_scratch = nv;
                12'h341: m_epc = nv;
                12'h342: m_cause = nv;
                12'h343: m_tval = nv;
                12'hB00: begin m_cyc[31:0] = nv;  wr_cyc = 1; end
                12'hB80: begin m_cyc[63:32] = nv; wr_cyc = 1; end
                12'hB02: begin m_ret[31:0] = nv;  wr_ret = 1; end
                12'hB82: begin m_ret[63:32] = nv; wr_ret = 1; end
                default: ;
            endcase
        end
        if (!wr_cyc && !m_inh[0]) m_cyc = m_cyc + 1;
        if (!wr_ret && incr && !m_inh[2]) m_ret = m_ret + 1;
        if (take_exc || take_irq) begin
            m_tpc   = (m_tvec & ~32'h3) + ((take_irq && m_tvec[1:0] == 2'd1) ? 32'(4 * code) : 32'h0);
            m_epc   = pc;
            m_cause = take_exc ? cause : (32'h8000_0000 | 32'(code));
            m_tval  = take_exc ? ((badaddr == 32'hFFFF_FFFF) ? pc : badaddr) : 32'h0;
            m_mpie  = m_mie_b; m_mie_b = 0; m_mpp = m_priv; m_priv = 2'd3; m_tv = 1;
        end else if (do_mret) begin
            m_tpc = m_epc; m_tv = 1;
            m_priv = m_mpp;
            if (m_mpp != 2'd3) m_mprv = 0;
            m_mie_b = m_mpie; m_mpie = 1; m_mpp = 2'd0;
        end
        if (!m_sleep) begin
            if (wfi && p == 0) m_sleep = 1;
        end else if (p != 0) m_sleep = 0;
        m_ip = (msip ? 32'h8 : 32'h0) | (mtip ? 32'h80 : 32'h0) | (meip ? 32'h800 : 32'h0) | (32'(loc) << 16);
    endtask

    always @(posedge clk) model_step();

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mstatus", mstatus, m_status());
            check("mie", mie, m_ie);
            check("mip", mip, m_ip);
            check("priv", 32'(priv), 32'(m_priv));
            check("trap_valid", 32'(trap_valid), 32'(m_tv));
            if (m_tv) check("trap_pc", trap_pc, m_tpc);
            check("wfi_stall", 32'(stall), 32'(m_sleep));
            check("rdata", rdata, csr_re ? m_read(addr) : 32'h0);
            check("fault", 32'(fault), 32'(m_fault()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [2:0] o, input logic [31:0] d, input logic [4:0] im);
        addr = a; op = o; rs1 = d; uimm = im; csr_we = 1; csr_re = 1;
        tick();
        csr_we = 0; csr_re = 0;
    endtask

    task automatic csr_rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        addr = a; csr_re = 1;
        @(negedge clk);
        check(nm, rdata, exp);
        tick();
        csr_re = 0;
    endtask

    task automatic wait_trap(input string nm, input logic [31:0] exp_pc);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (trap_valid === 1'b1) begin
                seen = 1;
                check(nm, trap_pc, exp_pc);
            end
            tick();
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s: trap_valid timeout got 0 expected 1", nm);
        end
    endtask

    initial begin
        rst = 1; incr = 0; csr_we = 0; csr_re = 0; exc = 0; mret = 0; wfi = 0; bnd = 0;
        msip = 0; mtip = 0; meip = 0; addr = 0; op = OP_RW; rs1 = 0; cause = 0; pc = 0;
        badaddr = 0; uimm = 0; loc = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 0;

        // mtvec reset value and WARL mode
        csr_rd("mtvec_init", 12'h305, 32'h8000_0001);
        csr_wr(12'h305, OP_RW, 32'h102, 5'd0);
        csr_rd("mtvec_warl", 12'h305, 32'h100);
        csr_rd("mvendorid", 12'hF11, 32'h6b69_616e);

        // timer interrupt, vectored
        csr_wr(12'h304, OP_RW, 32'h80, 5'd0);
        csr_wr(12'h300, OP_RSI, 32'h0, 5'd8);
        csr_wr(12'h305, OP_RW, 32'h101, 5'd0);
        pc = 32'h40; bnd = 1; mtip = 1;
        wait_trap("mti_trap_pc", 32'h11C);
        bnd = 0; mtip = 0;
        @(negedge clk);
        check("mstatus_after_mti", mstatus, 32'h1880);
        tick();
        csr_rd("mepc_mti", 12'h341, 32'h40);
        csr_rd("mcause_mti", 12'h342, 32'h8000_0007);

        // priority MEI > MSI > local
        csr_wr(12'h304, OP_RW, 32'h0004_0888, 5'd0);
        meip = 1; msip = 1; loc = 4'b0100;
        csr_wr(12'h300, OP_RSI, 32'h0, 5'd8);
        bnd = 1;
        wait_trap("mei_trap_pc", 32'h12C);
        bnd = 0; meip = 0;
        csr_rd("mcause_mei", 12'h342, 32'h8000_000B);
        csr_wr(12'h300, OP_RSI, 32'h0, 5'd8);
        bnd = 1;
        wait_trap("msi_trap_pc", 32'h10C);
        bnd = 0; msip = 0; loc = 0;
        csr_rd("mcause_msi", 12'h342, 32'h8000_0003);

        // WFI sleep and wake with MIE=0
        csr_wr(12'h304, OP_RW, 32'h1_0000, 5'd0);
        wfi = 1; tick(); wfi = 0;
        @(negedge clk);
        check("wfi_sleep", 32'(stall), 32'h1);
        tick();
        loc = 4'b0001;
        tick();
        @(negedge clk);
        check("wfi_hold_mip", 32'(stall), 32'h1);
        tick();
        @(negedge clk);
        check("wfi_wake", 32'(stall), 32'h0);
        check("wfi_no_trap", 32'(trap_valid), 32'h0);
        tick();
        loc = 0;

        // exception beats mret and a CSR write
        csr_wr(12'h340, OP_RW, 32'h55, 5'd0);
        exc = 1; cause = 32'd2; badaddr = 32'hFFFF_FFFF; pc = 32'h20; mret = 1;
        csr_we = 1; addr = 12'h340; op = OP_RW; rs1 = 32'hDEAD;
        tick();
        exc = 0; mret = 0; csr_we = 0;
        @(negedge clk);
        check("exc_trap_valid", 32'(trap_valid), 32'h1);
        check("exc_trap_pc", trap_pc, 32'h100);
        tick();
        csr_rd("mcause_exc", 12'h342, 32'h2);
        csr_rd("mtval_exc", 12'h343, 32'h20);
        csr_rd("mscratch_kept", 12'h340, 32'h55);

        // mret into U mode, then privilege faults
        csr_wr(12'h300, OP_RC, 32'h1800, 5'd0);
        mret = 1; tick(); mret = 0;
        @(negedge clk);
        check("mret_pc", trap_pc, 32'h20);
        check("mret_priv", 32'(priv), 32'h0);
        tick();
        addr = 12'h300; csr_re = 1;
        @(negedge clk);
        check("u_mstatus_fault", 32'(fault), 32'h1);
        tick();
        addr = 12'hC00;
        @(negedge clk);
        check("u_cycle_ok", 32'(fault), 32'h0);
        tick();
        csr_re = 0;
        exc = 1; cause = 32'd8; badaddr = 32'h0; pc = 32'h30;
        tick();
        exc = 0;
        addr = 12'hC00; op = OP_RW; rs1 = 32'h5; csr_we = 1;
        @(negedge clk);
        check("ro_cycle_fault", 32'(fault), 32'h1);
        tick();
        csr_we = 0;

        // counters and mcountinhibit
        csr_wr(12'h320, OP_RWI, 32'h0, 5'd1);
`ifdef CSR_MCOUNTINHIBIT_EN
        csr_rd("mcountinhibit", 12'h320, 32'h1);
`else
        csr_rd("mcountinhibit", 12'h320, 32'h0);
`endif
        addr = 12'hC00; csr_re = 1;
        for (int i = 0; i < 10; i++) begin
            incr = (i % 3 == 0);
            tick();
        end
        incr = 0;
        csr_wr(12'h320, OP_RWI, 32'h0, 5'd5);
        addr = 12'hB02; csr_re = 1; incr = 1;
        for (int i = 0; i < 4; i++) tick();
        incr = 0; csr_re = 0;
        csr_wr(12'h320, OP_RWI, 32'h0, 5'd0);

        // reset in the middle of sleep
        csr_wr(12'h304, OP_RW, 32'h0, 5'd0);
        wfi = 1; tick(); wfi = 0;
        @(negedge clk);
        check("sleep_before_rst", 32'(stall), 32'h1);
        tick();
        rst = 1; tick(); rst = 0;
        @(negedge clk);
        check("rst_abort_sleep", 32'(stall), 32'h0);
        tick();
        csr_rd("mtvec_after_rst", 12'h305, 32'h8000_0001);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
